// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage.
//   XLEN      : operand/data width
//   NREG      : architectural register count
//   REG_IDX_W : register index width
//   alu_op_e  : shared ALU opcode encoding
package alu_issue_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_issue_if.sv
// Bus bundle for the issue stage: decode handshake, issue bundle, writeback.
//   slave  : view of the issue stage itself
//   master : view of the surrounding pipeline (decode, ALU, writeback)
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic                 dec_valid;
    logic                 dec_ready;
    logic [REG_IDX_W-1:0] dec_rs1;
    logic [REG_IDX_W-1:0] dec_rs2;
    logic [REG_IDX_W-1:0] dec_rd;
    alu_op_e              dec_op;
    logic                 dec_use_imm;
    logic [XLEN-1:0]      dec_imm;
    logic                 dec_rd_we;

    logic                 iss_valid;
    logic                 iss_ready;
    logic [XLEN-1:0]      iss_a;
    logic [XLEN-1:0]      iss_b;
    alu_op_e              iss_op;
    logic [REG_IDX_W-1:0] iss_rd;
    logic                 iss_rd_we;

    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_op, dec_use_imm, dec_imm, dec_rd_we,
        output dec_ready,
        output iss_valid, iss_a, iss_b, iss_op, iss_rd, iss_rd_we,
        input  iss_ready,
        input  wb_valid, wb_rd, wb_data
    );

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_op, dec_use_imm, dec_imm, dec_rd_we,
        input  dec_ready,
        input  iss_valid, iss_a, iss_b, iss_op, iss_rd, iss_rd_we,
        output iss_ready,
        output wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/alu_regfile.sv
// Integer register file: two combinational read ports, one write port.
// Reads of index 0 return 0; a same-cycle writeback to the read index is
// forwarded so the reader sees the value being written this cycle.
//   clk, rst_n         : clock, asynchronous active-low reset
//   rs1_idx / rs1_data : read port A
//   rs2_idx / rs2_data : read port B
//   wb_valid/rd/data   : write port (writes to index 0 are dropped)
module alu_regfile
    import alu_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_idx];
        if (rs1_idx == '0) begin
            rs1_data = '0;
        end else if (wb_valid && (wb_rd == rs1_idx)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_idx];
        if (rs2_idx == '0) begin
            rs2_data = '0;
        end else if (wb_valid && (wb_rd == rs2_idx)) begin
            rs2_data = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Operand-fetch / issue stage in front of the integer ALU.
// Reads operands from alu_regfile, stalls on pending writes tracked by a
// scoreboard, and holds a registered bundle for the ALU.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : decode handshake in, issue bundle out, writeback in
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no bundle held, iss_valid = 0
// ST_FULL  | bundle held on iss_*, waits for iss_ready
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    alu_issue_if.slave bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] rd_set;
    logic [NREG-1:0] eff_pend;
    logic [NREG-1:0] pending_nxt;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    alu_regfile u_regfile (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .rs1_idx  (bus.dec_rs1),
        .rs2_idx  (bus.dec_rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_valid (bus.wb_valid),
        .wb_rd    (bus.wb_rd),
        .wb_data  (bus.wb_data)
    );

    // A writeback landing this cycle already resolves its register's hazard,
    // since the operand is forwarded from the write port.
    always_comb begin
        wb_clr = '0;
        if (bus.wb_valid) begin
            wb_clr[bus.wb_rd] = 1'b1;
        end
    end

    assign eff_pend = pending & ~wb_clr;

    // pending[0] is held at 0, so index-0 terms never raise a hazard.
    assign hazard = eff_pend[bus.dec_rs1]
                  | (!bus.dec_use_imm & eff_pend[bus.dec_rs2])
                  | (bus.dec_rd_we & eff_pend[bus.dec_rd]);

    assign bus.iss_valid = (state == ST_FULL);
    assign bus.dec_ready = !hazard && (!bus.iss_valid || bus.iss_ready);
    assign accept        = bus.dec_valid && bus.dec_ready;

    always_comb begin
        rd_set = '0;
        if (accept && bus.dec_rd_we && (bus.dec_rd != '0)) begin
            rd_set[bus.dec_rd] = 1'b1;
        end
    end

    // Clear first, then OR in the new writer: a same-cycle set beats the clear.
    always_comb begin
        pending_nxt    = eff_pend | rd_set;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_FULL;
                ST_FULL:  if (bus.iss_ready && !accept) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.iss_a     <= '0;
            bus.iss_b     <= '0;
            bus.iss_op    <= ALU_ADD;
            bus.iss_rd    <= '0;
            bus.iss_rd_we <= 1'b0;
        end else if (accept) begin
            bus.iss_a     <= rs1_data;
            bus.iss_b     <= bus.dec_use_imm ? bus.dec_imm : rs2_data;
            bus.iss_op    <= bus.dec_op;
            bus.iss_rd    <= bus.dec_rd;
            bus.iss_rd_we <= bus.dec_rd_we;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural reference model and a
// per-cycle comparison on the falling clock edge.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_issue_if bus ();

    alu_issue dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_rf [32];
    bit   [31:0] m_pend;
    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    bit          m_we;

    function automatic bit wb_hits(int r);
        return bus.wb_valid && (int'(bus.wb_rd) == r);
    endfunction

    function automatic bit busy(int r);
        return (r != 0) && m_pend[r] && !wb_hits(r);
    endfunction

    function automatic bit model_ready();
        bit haz;
        haz = busy(int'(bus.dec_rs1))
           || (!bus.dec_use_imm && busy(int'(bus.dec_rs2)))
           || (bus.dec_rd_we && busy(int'(bus.dec_rd)));
        return !haz && (!m_valid || bus.iss_ready);
    endfunction

    function automatic logic [31:0] operand(int r);
        if (r == 0) return 32'h0;
        if (wb_hits(r)) return bus.wb_data;
        return m_rf[r];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            m_op    <= '0;
            m_rd    <= '0;
            m_we    <= 1'b0;
        end else begin
            if (bus.wb_valid && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] <= bus.wb_data;
            if (bus.wb_valid) m_pend[bus.wb_rd] <= 1'b0;
            if (bus.dec_valid && model_ready()) begin
                if (bus.dec_rd_we && bus.dec_rd != 5'd0) m_pend[bus.dec_rd] <= 1'b1;
                m_valid <= 1'b1;
                m_a     <= operand(int'(bus.dec_rs1));
                m_b     <= bus.dec_use_imm ? bus.dec_imm : operand(int'(bus.dec_rs2));
                m_op    <= bus.dec_op;
                m_rd    <= bus.dec_rd;
                m_we    <= bus.dec_rd_we;
            end else if (bus.iss_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_dec_ready", 32'(bus.dec_ready), 32'(model_ready()));
            check("cyc_iss_valid", 32'(bus.iss_valid), 32'(m_valid));
            if (m_valid) begin
                check("cyc_iss_a", bus.iss_a, m_a);
                check("cyc_iss_b", bus.iss_b, m_b);
                check("cyc_iss_op", 32'(bus.iss_op), 32'(m_op));
                check("cyc_iss_rd", 32'(bus.iss_rd), 32'(m_rd));
                check("cyc_iss_rd_we", 32'(bus.iss_rd_we), 32'(m_we));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input bit v, input alu_op_e op, input int rs1, input int rs2,
                           input int rd, input bit we, input bit ui, input logic [31:0] imm);
        bus.dec_valid   = v;
        bus.dec_op      = op;
        bus.dec_rs1     = 5'(rs1);
        bus.dec_rs2     = 5'(rs2);
        bus.dec_rd      = 5'(rd);
        bus.dec_rd_we   = we;
        bus.dec_use_imm = ui;
        bus.dec_imm     = imm;
    endtask

    task automatic set_wb(input bit v, input int rd, input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_rd    = 5'(rd);
        bus.wb_data  = d;
    endtask

    initial begin
        set_dec(1'b0, ALU_ADD, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        set_wb(1'b0, 0, 32'h0);
        bus.iss_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check("rst_iss_valid", 32'(bus.iss_valid), 32'h0);
        check("rst_iss_a", bus.iss_a, 32'h0);
        check("rst_iss_b", bus.iss_b, 32'h0);
        check("rst_iss_op", 32'(bus.iss_op), 32'h0);
        check("rst_iss_rd", 32'(bus.iss_rd), 32'h0);
        check("rst_iss_rd_we", 32'(bus.iss_rd_we), 32'h0);
        check("rst_dec_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        rst_n = 1'b1;

        // Basic issue with operands from the file
        set_wb(1'b1, 5, 32'h0000_0010); tick();
        set_wb(1'b1, 6, 32'h0000_0003); tick();
        set_wb(1'b0, 0, 32'h0);
        set_dec(1'b1, ALU_ADD, 5, 6, 7, 1'b1, 1'b0, 32'h0); tick();
        check("add_valid", 32'(bus.iss_valid), 32'h1);
        check("add_a", bus.iss_a, 32'h10);
        check("add_b", bus.iss_b, 32'h3);
        check("add_op", 32'(bus.iss_op), 32'(ALU_ADD));
        check("add_rd", 32'(bus.iss_rd), 32'd7);
        check("add_we", 32'(bus.iss_rd_we), 32'h1);

        // RAW stall on x7 until its writeback, then bypass
        set_dec(1'b1, ALU_SUB, 7, 6, 8, 1'b1, 1'b0, 32'h0);
        #1 check("raw_stall0", 32'(bus.dec_ready), 32'h0);
        tick();
        #1 check("raw_stall1", 32'(bus.dec_ready), 32'h0);
        set_wb(1'b1, 7, 32'h13);
        #1 check("raw_wb_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        set_wb(1'b0, 0, 32'h0);
        check("raw_bypass_a", bus.iss_a, 32'h13);
        check("raw_op", 32'(bus.iss_op), 32'(ALU_SUB));

        // Downstream backpressure, then no-bubble refill
        set_dec(1'b1, ALU_ADD, 5, 6, 10, 1'b1, 1'b0, 32'h0);
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_a", bus.iss_a, 32'h13);
            check("hold_ready", 32'(bus.dec_ready), 32'h0);
            tick();
        end
        bus.iss_ready = 1'b1;
        #1 check("refill_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        check("refill_valid", 32'(bus.iss_valid), 32'h1);
        check("refill_a", bus.iss_a, 32'h10);
        check("refill_rd", 32'(bus.iss_rd), 32'd10);
        set_dec(1'b0, ALU_ADD, 0, 0, 0, 1'b0, 1'b0, 32'h0);

        // x0 stays zero; immediate operand; rd=x0 writers never stall
        set_wb(1'b1, 0, 32'hFFFF_FFFF); tick();
        set_wb(1'b0, 0, 32'h0);
        set_dec(1'b1, ALU_OR, 0, 8, 0, 1'b1, 1'b1, 32'h0000_0AAA);
        #1 check("x0_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        check("x0_a", bus.iss_a, 32'h0);
        check("imm_b", bus.iss_b, 32'hAAA);
        #1 check("x0_writer_ready", 32'(bus.dec_ready), 32'h1);
        tick();

        // WAW on x9, including a same-cycle writeback and new writer
        set_dec(1'b1, ALU_ADD, 0, 0, 9, 1'b1, 1'b1, 32'h1); tick();
        #1 check("waw_stall0", 32'(bus.dec_ready), 32'h0);
        tick();
        #1 check("waw_stall1", 32'(bus.dec_ready), 32'h0);
        set_wb(1'b1, 9, 32'h99);
        #1 check("waw_wb_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        set_wb(1'b0, 0, 32'h0);
        set_dec(1'b1, ALU_XOR, 9, 0, 11, 1'b1, 1'b1, 32'h2);
        #1 check("waw_still_pending", 32'(bus.dec_ready), 32'h0);
        set_wb(1'b1, 9, 32'h55);
        #1 check("waw_clear_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        set_wb(1'b0, 0, 32'h0);
        check("waw_bypass_a", bus.iss_a, 32'h55);

        // Asynchronous reset while FULL with x3 pending
        set_dec(1'b1, ALU_ADD, 0, 0, 3, 1'b1, 1'b1, 32'h7); tick();
        set_dec(1'b0, ALU_ADD, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        bus.iss_ready = 1'b0;
        #1 check("pre_rst_valid", 32'(bus.iss_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1 check("async_rst_valid", 32'(bus.iss_valid), 32'h0);
        check("async_rst_a", bus.iss_a, 32'h0);
        tick();
        rst_n = 1'b1;
        bus.iss_ready = 1'b1;
        set_dec(1'b1, ALU_AND, 3, 3, 12, 1'b1, 1'b0, 32'h0);
        #1 check("post_rst_ready", 32'(bus.dec_ready), 32'h1);
        tick();
        check("post_rst_a", bus.iss_a, 32'h0);
        check("post_rst_b", bus.iss_b, 32'h0);
        set_dec(1'b0, ALU_ADD, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        set_wb(1'b1, 3, 32'h33); tick();
        set_wb(1'b0, 0, 32'h0);
        set_dec(1'b1, ALU_ADD, 3, 5, 13, 1'b0, 1'b0, 32'h0); tick();
        check("post_rst_wb_a", bus.iss_a, 32'h33);
        check("post_rst_wb_b", bus.iss_b, 32'h0);
        set_dec(1'b0, ALU_ADD, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-fetch and issue stage directly upstream of the integer ALU. Accepts decoded instructions over a valid/ready handshake and reads operands from an internal 32x32 register file, bypassing same-cycle writeback. It stalls on register hazards via a pending-write scoreboard and presents a registered operand/opcode bundle to the ALU and the downstream result path. Register-file writes arrive from the writeback stage.

## Interface

- XLEN, 32, operand/data width
- NREG, 32, architectural register count (index width = $clog2(NREG) = 5)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_dec_valid  in  1  decoded instruction present
- o_dec_ready  out  1  stage accepts instruction this cycle
- i_dec_rs1, i_dec_rs2, i_dec_rd  in  5 each  source/destination indices
- i_dec_op  in  4  ALU opcode (shared opcode encoding)
- i_dec_use_imm  in  1  operand B = immediate, rs2 ignored
- i_dec_imm  in  XLEN  sign-extended immediate
- i_dec_rd_we  in  1  instruction writes rd
- o_iss_valid  out  1  issue bundle valid
- i_iss_ready  in  1  downstream consumes bundle
- o_iss_a, o_iss_b  out  XLEN  ALU operands
- o_iss_op  out  4  ALU opcode
- o_iss_rd  out  5; o_iss_rd_we  out  1  destination passed through
- i_wb_valid  in  1; i_wb_rd  in  5; i_wb_data  in  XLEN  writeback port

## Operation

- Output register FSM: EMPTY (o_iss_valid=0) / FULL (o_iss_valid=1). Accept → FULL; FULL & i_iss_ready & no accept → EMPTY; FULL & i_iss_ready & accept → FULL with new bundle; FULL & !i_iss_ready → hold all outputs stable.
- Accept = i_dec_valid & o_dec_ready. o_dec_ready = !hazard & (!o_iss_valid | i_iss_ready), combinational.
- Operand read: index 0 → 0; else if i_wb_valid & i_wb_rd == index → i_wb_data (bypass); else register file.
- o_iss_b = i_dec_imm when i_dec_use_imm, else rs2 operand.
- Scoreboard: NREG-bit pending vector, bit 0 always 0. Set bit rd on accept when i_dec_rd_we & rd≠0. Clear bit i_wb_rd on i_wb_valid. Same-cycle set and clear of the same bit: set wins.
- Effective pending = pending & ~(i_wb_valid ? onehot(i_wb_rd) : 0), i.e. a same-cycle writeback resolves the hazard.
- hazard = effpend[rs1] | (!use_imm & effpend[rs2]) | (rd_we & effpend[rd]) (WAW). Index-0 terms are always 0.
- Register file: written on i_wb_valid at the clock edge; writes to index 0 are dropped. Writeback to a non-pending register is legal and updates the file.
- Reset (async assert): o_iss_valid=0; o_iss_a/b=0; o_iss_op=0; o_iss_rd=0; o_iss_rd_we=0; scoreboard=0; all registers=0. o_dec_ready is 1 after reset if i_dec_valid carries no hazard.

## Timing

- Latency: instruction accepted at edge N appears on o_iss_* after edge N; the ALU result is combinational from there.
- Throughput: 1 instr/cycle when there is no hazard and downstream is ready.
- Back-to-back dependency (rd of instr k = rs of k+1) stalls until the writeback cycle of rd. That writeback cycle itself may issue via the bypass.
- i_dec_* must be held stable while i_dec_valid & !o_dec_ready. Outputs are held while o_iss_valid & !i_iss_ready.
- Reset mid-operation: the in-flight bundle is dropped and pending bits are lost. Writebacks after reset still update the file.

## Structure

- The shared package holds XLEN, NREG, REG_IDX_W=5 and the ALU opcode typedef/constants. Opcodes come from the existing shared opcode header and are not redefined here.
- One sub-module, alu_regfile:
  - 2 combinational read ports with writeback bypass and x0=0.
  - 1 write port.
  - asynchronous active-low reset.
- The scoreboard, hazard logic and output FSM live in alu_issue.

## Test plan

- Reset, then WB x5=0x0000_0010 and x6=0x0000_0003; issue ADD rd=x7 rs1=x5 rs2=x6 → next cycle o_iss_a=0x10, o_iss_b=0x3, o_iss_op=ADD, o_iss_rd=7, o_iss_rd_we=1.
- Issue instr writing x7, then SUB rs1=x7 → o_dec_ready=0 until WB x7=0x13. In that WB cycle SUB is accepted with o_iss_a=0x13 via the bypass.
- i_iss_ready=0 for 3 cycles with a bundle FULL → o_iss_* unchanged and o_dec_ready=0. Raising ready with the next instr valid → new bundle issued the next cycle, no bubble.
- WB x0=0xFFFF_FFFF, then issue OR rs1=x0, use_imm=1, imm=0x0000_0AAA → o_iss_a=0, o_iss_b=0xAAA. A rd=x0 writer never sets pending or stalls.
- WAW: pending x9, issue a new writer of x9 → stall. WB x9 while accepting a new x9 writer in the same cycle → pending[9] remains 1.
- Assert i_rst_n=0 asynchronously while FULL with pending x3 → o_iss_valid drops immediately. After release, a reader of x3 issues with no stall and operand 0.
